lif_array: RTL

Time-multiplexed array of N_CH leaky integrate-and-fire neurons sharing one update datapath. It is the parametrised successor to the single-neuron core that sits behind the chip's top-level wrapper, with these additions:
- configurable channel count, width and leak;
- programmable threshold;
- refractory period;
- saturating arithmetic;
- frame-level spike reporting.

It sits directly under the top-level wrapper. Stimulus comes from input pins, and spikes and state go to outputs.

---
 rtl/lif_pkg.sv | 15 +
 rtl/lif_core.sv | 50 +++++
 rtl/lif_array.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron array.
// Holds the default array geometry, the refractory counter width and the spike-counter width.
package lif_pkg;

    localparam int unsigned NChDefault      = 4;
    localparam int unsigned WDefault        = 8;
    localparam int unsigned LeakShiftDefault = 2;
    localparam int unsigned RefracDefault   = 2;

    // Refractory counter per channel; REFRAC may be at most 2^RefrW - 1.
    localparam int unsigned RefrW = 4;
    // Total spike counter, saturating.
    localparam int unsigned CntW  = 16;

endpackage

// File: rtl/lif_core.sv
// One combinational leaky integrate-and-fire update.
// Ports:
//   v_i          current membrane value
//   refr_i       current refractory count (0 = not refractory)
//   stim_i       unsigned stimulus for this update
//   threshold_i  unsigned firing threshold
//   v_next_o     membrane value after the update
//   refr_next_o  refractory count after the update
//   fired_o      1 when this update produced a spike
module lif_core
    import lif_pkg::*;
#(
    parameter int unsigned W          = WDefault,
    parameter int unsigned LEAK_SHIFT = LeakShiftDefault,
    parameter int unsigned REFRAC     = RefracDefault
) (
    input  logic [W-1:0]     v_i,
    input  logic [RefrW-1:0] refr_i,
    input  logic [W-1:0]     stim_i,
    input  logic [W-1:0]     threshold_i,
    output logic [W-1:0]     v_next_o,
    output logic [RefrW-1:0] refr_next_o,
    output logic             fired_o
);

    logic [W-1:0] v_leak;
    logic [W:0]   sum_wide;
    logic [W-1:0] sum_sat;

    // V - (V >> s) cannot underflow since (V >> s) <= V.
    assign v_leak   = v_i - (v_i >> LEAK_SHIFT);
    assign sum_wide = {1'b0, v_leak} + {1'b0, stim_i};
    assign sum_sat  = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];

    always_comb begin
        v_next_o    = '0;
        refr_next_o = '0;
        fired_o     = 1'b0;
        if (refr_i != '0) begin
            // Refractory: membrane clamped, stimulus ignored.
            refr_next_o = refr_i - 1'b1;
        end else if (sum_sat >= threshold_i) begin
            fired_o     = 1'b1;
            refr_next_o = RefrW'(REFRAC);
        end else begin
            v_next_o = sum_sat;
        end
    end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of N_CH leaky integrate-and-fire neurons sharing one lif_core.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            process channel ch and advance the pointer this cycle
//   stim_current  per-channel stimulus, channel k at [k*W +: W]
//   threshold     firing threshold shared by all channels
//   mon_sel       channel whose membrane value drives mon_state (combinational)
//   spike_pulse   registered fire flag of the just-updated channel
//   spike_ch      channel of the last update
//   spike_vec     fire flags of the last completed frame
//   frame_done    one-cycle pulse when spike_vec is refreshed
//   spike_count   saturating total spike count
module lif_array
    import lif_pkg::*;
#(
    parameter int unsigned N_CH       = NChDefault,
    parameter int unsigned W          = WDefault,
    parameter int unsigned LEAK_SHIFT = LeakShiftDefault,
    parameter int unsigned REFRAC     = RefracDefault
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_CH*W-1:0]         stim_current,
    input  logic [W-1:0]              threshold,
    input  logic [$clog2(N_CH)-1:0]   mon_sel,
    output logic [W-1:0]              mon_state,
    output logic                      spike_pulse,
    output logic [$clog2(N_CH)-1:0]   spike_ch,
    output logic [N_CH-1:0]           spike_vec,
    output logic                      frame_done,
    output logic [CntW-1:0]           spike_count
);

    localparam int unsigned ChW = $clog2(N_CH);

    logic [W-1:0]     v_q    [N_CH];
    logic [RefrW-1:0] refr_q [N_CH];
    logic [W-1:0]     stim_arr [N_CH];

    logic [ChW-1:0]  ch_q, ch_d;
    logic [N_CH-1:0] acc_q, acc_d;
    logic [N_CH-1:0] spike_vec_q, spike_vec_d;
    logic [ChW-1:0]  spike_ch_q, spike_ch_d;
    logic            spike_pulse_q, spike_pulse_d;
    logic            frame_done_q, frame_done_d;
    logic [CntW-1:0] count_q, count_d;

    logic [W-1:0]     v_next;
    logic [RefrW-1:0] refr_next;
    logic             fired;
    logic             last_ch;

    for (genvar k = 0; k < N_CH; k++) begin : g_stim
        assign stim_arr[k] = stim_current[k*W +: W];
    end

    lif_core #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC)
    ) u_core (
        .v_i         (v_q[ch_q]),
        .refr_i      (refr_q[ch_q]),
        .stim_i      (stim_arr[ch_q]),
        .threshold_i (threshold),
        .v_next_o    (v_next),
        .refr_next_o (refr_next),
        .fired_o     (fired)
    );

    assign last_ch = (ch_q == ChW'(N_CH - 1));

    always_comb begin
        ch_d          = ch_q;
        acc_d         = acc_q;
        spike_vec_d   = spike_vec_q;
        spike_ch_d    = spike_ch_q;
        spike_pulse_d = 1'b0;
        frame_done_d  = 1'b0;
        count_d       = count_q;
        if (en) begin
            ch_d          = ch_q + 1'b1;  // wraps: N_CH is a power of two
            spike_pulse_d = fired;
            spike_ch_d    = ch_q;
            acc_d[ch_q]   = fired;
            if (last_ch) begin
                // Last channel's result bypasses acc so the frame vector is complete now.
                spike_vec_d  = {fired, acc_q[N_CH-2:0]};
                frame_done_d = 1'b1;
                acc_d        = '0;
            end
            if (fired && (count_q != {CntW{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                v_q[k]    <= '0;
                refr_q[k] <= '0;
            end
            ch_q          <= '0;
            acc_q         <= '0;
            spike_vec_q   <= '0;
            spike_ch_q    <= '0;
            spike_pulse_q <= 1'b0;
            frame_done_q  <= 1'b0;
            count_q       <= '0;
        end else begin
            if (en) begin
                v_q[ch_q]    <= v_next;
                refr_q[ch_q] <= refr_next;
            end
            ch_q          <= ch_d;
            acc_q         <= acc_d;
            spike_vec_q   <= spike_vec_d;
            spike_ch_q    <= spike_ch_d;
            spike_pulse_q <= spike_pulse_d;
            frame_done_q  <= frame_done_d;
            count_q       <= count_d;
        end
    end

    assign mon_state   = v_q[mon_sel];
    assign spike_pulse = spike_pulse_q;
    assign spike_ch    = spike_ch_q;
    assign spike_vec   = spike_vec_q;
    assign frame_done  = frame_done_q;
    assign spike_count = count_q;

endmodule
